// File: rtl/rv32_mod_load_store_unit.sv
// RV32 load/store unit: accepts one decoded memory access, drives a simple
// req/ack bus, aligns and extends load data, and flags misaligned, illegal or timed-out accesses.
module rv32_mod_load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [3:0]  ram_req,
  input  logic        ram_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  localparam logic [16:0] TMO_LIMIT = 17'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  f3_q, f3_d;
  logic        wr_q, wr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fail_q, fail_d;

  logic        req_legal;
  logic        req_aligned;
  logic [16:0] cnt_inc;
  logic [31:0] lane_data;
  logic [31:0] load_ext;
  logic [3:0]  be_calc;
  logic [31:0] wdata_rep;
  logic        in_access;

  // Bit 3 of ram_req carries no meaning for this unit.
  logic unused_ram_req3;
  assign unused_ram_req3 = ram_req[3];

  always_comb begin
    req_legal = 1'b0;
    if (ram_wr) begin
      req_legal = (ram_req[2:0] == 3'b000) || (ram_req[2:0] == 3'b001) ||
                  (ram_req[2:0] == 3'b010);
    end else begin
      req_legal = (ram_req[2:0] == 3'b000) || (ram_req[2:0] == 3'b001) ||
                  (ram_req[2:0] == 3'b010) || (ram_req[2:0] == 3'b100) ||
                  (ram_req[2:0] == 3'b101);
    end
  end

  always_comb begin
    req_aligned = 1'b1;
    case (ram_req[1:0])
      2'b01:   req_aligned = (addr[0] == 1'b0);
      2'b10:   req_aligned = (addr[1:0] == 2'b00);
      default: req_aligned = 1'b1;
    endcase
  end

  assign cnt_inc   = {1'b0, cnt_q} + 17'd1;
  assign lane_data = mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_ext = lane_data;
    case (f3_q)
      3'b000:  load_ext = {{24{lane_data[7]}}, lane_data[7:0]};
      3'b001:  load_ext = {{16{lane_data[15]}}, lane_data[15:0]};
      3'b100:  load_ext = {24'd0, lane_data[7:0]};
      3'b101:  load_ext = {16'd0, lane_data[15:0]};
      default: load_ext = lane_data;
    endcase
  end

  always_comb begin
    be_calc   = 4'b1111;
    wdata_rep = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be_calc   = 4'b0001 << addr_q[1:0];
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_calc   = 4'b0011 << addr_q[1:0];
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: begin
        be_calc   = 4'b1111;
        wdata_rep = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    fail_d  = fail_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = addr;
          f3_d    = ram_req[2:0];
          wr_d    = ram_wr;
          wdata_d = wdata;
          cnt_d   = 16'd0;
          if (req_legal && req_aligned) begin
            fail_d  = 1'b0;
            state_d = S_ACCESS;
          end else begin
            fail_d  = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_ACCESS: begin
        // An ack in the final allowed cycle still wins over the timeout.
        if (mem_ack) begin
          if (!wr_q) begin
            rdata_d = load_ext;
          end
          fail_d  = 1'b0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_inc[15:0];
          if (cnt_inc == TMO_LIMIT) begin
            fail_d  = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= 32'd0;
      f3_q    <= 3'd0;
      wr_q    <= 1'b0;
      wdata_q <= 32'd0;
      cnt_q   <= 16'd0;
      rdata_q <= 32'd0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fail_q  <= fail_d;
    end
  end

  // Bus outputs come straight from state so reset removes mem_req immediately.
  assign in_access = (state_q == S_ACCESS);
  assign mem_req   = in_access;
  assign mem_we    = in_access & wr_q;
  assign mem_addr  = in_access ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_be    = in_access ? be_calc : 4'd0;
  assign mem_wdata = in_access ? wdata_rep : 32'd0;

  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_RESP) & ~fail_q;
  assign err   = (state_q == S_RESP) & fail_q;
  assign rdata = rdata_q;

endmodule

// File: doc/rv32_mod_load_store_unit.md
RV32_MOD_LOAD_STORE_UNIT -- requirements
Module: rv32_mod_load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum ACCESS cycles without mem_ack before abort (legal 1..65535).
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  access request from decoder; sampled only in IDLE.
REQ-005 ram_req  in  4  [2:0] = funct3 (width/signedness); [3] ignored.
REQ-006 ram_wr  in  1  1 = store, 0 = load.
REQ-007 addr  in  32  byte address (ALU add result).
REQ-008 wdata  in  32  store data (rs2); low byte/half used for SB/SH.
REQ-009 busy  out  1  high whenever state != IDLE (pipeline stall).
REQ-010 done  out  1  one-cycle pulse on successful completion.
REQ-011 err  out  1  one-cycle pulse on misaligned, illegal funct3 or timeout.
REQ-012 rdata  out  32  extended load result, valid when done=1 on a load.
REQ-013 mem_req  out  1  bus request, held until acknowledged.
REQ-014 mem_we  out  1  bus write enable.
REQ-015 mem_addr  out  32  word address, [1:0] always 0.
REQ-016 mem_be  out  4  byte enables.
REQ-017 mem_wdata  out  32  lane-replicated store data.
REQ-018 mem_ack  in  1  bus acknowledge; ignored outside ACCESS.
REQ-019 mem_rdata  in  32  bus read data, valid with mem_ack on loads.

Function
REQ-020 FSM states IDLE, ACCESS, RESP; IDLE & req_valid -> ACCESS if legal and aligned, else RESP with error flag.
REQ-021 Legal funct3: loads 000,001,010,100,101; stores 000,001,010; all others illegal.
REQ-022 Alignment: half requires addr[0]=0; word requires addr[1:0]=00; otherwise misaligned.
REQ-023 Request fields (addr, width, sign, wr, wdata) registered on acceptance; later input changes have no effect.
REQ-024 ACCESS: mem_req=1 with mem_we/mem_addr/mem_be/mem_wdata stable every cycle until mem_ack sampled high.
REQ-025 mem_ack high in ACCESS -> capture mem_rdata, go RESP.
REQ-026 RESP: exactly one cycle; done=1 (success) or err=1 (error), never both; then IDLE.
REQ-027 req_valid ignored in ACCESS and RESP; new request accepted earliest in the first IDLE cycle.
REQ-028 Latency: req accepted edge N -> mem_req from cycle N+1; ack in cycle K -> done in cycle K+1; minimum 2 cycles request to done.
REQ-029 Illegal/misaligned: no mem_req ever asserted; err in cycle after request.
REQ-030 mem_be: byte = 0001<<addr[1:0]; half = 0011<<addr[1:0]; word = 1111; same for loads and stores.
REQ-031 mem_wdata: byte replicated x4, half replicated x2, word unchanged.
REQ-032 Load extraction from lane addr[1:0]; sign-extend for 000/001, zero-extend for 100/101, word unchanged.
REQ-033 Timeout counter cleared on ACCESS entry, increments each ACCESS cycle without ack; reaching TIMEOUT_CYCLES -> drop mem_req, RESP with err.
REQ-034 mem_ack in the same cycle the counter reaches TIMEOUT_CYCLES counts as success.
REQ-035 All mem_* outputs 0 outside ACCESS; rdata holds last load result until next successful load.

Reset
REQ-036 rst_n low asynchronously forces IDLE, counter 0, rdata 0, all outputs 0.
REQ-037 Reset during ACCESS drops mem_req immediately; no done/err is emitted for the aborted access.
REQ-038 First request accepted in the first clock edge after rst_n deasserts.

Verification
REQ-039 LW addr 0x100, ack 2 cycles after mem_req, mem_rdata 0xDEADBEEF -> mem_addr 0x100, be 1111, done pulse, rdata 0xDEADBEEF.
REQ-040 LB addr 0x103, mem_rdata 0x80000000 -> be 1000, rdata 0xFFFFFF80; LBU same -> rdata 0x00000080.
REQ-041 SH addr 0x202, wdata 0x1234ABCD -> mem_addr 0x200, be 1100, mem_wdata 0xABCDABCD, mem_we 1, done.
REQ-042 LW addr 0x102, then ram_req 011 -> err pulse each, mem_req never high, done 0.
REQ-043 TIMEOUT_CYCLES=4, mem_ack held 0 -> mem_req high 4 cycles, then err pulse, busy low next cycle.
REQ-044 rst_n low mid-ACCESS -> mem_req 0 immediately, no done after release; next LW completes normally.
